uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Receive half of the 8-bit-bus UART. Companion to the transmit block on the same bus; consumes the serial `rx` line and presents bytes to the CPU.
- Line format: 8N1, LSB first.
- Recovers bit timing from a clock divider and samples at mid-bit.
- Exposes two registers on a 1-bit address: a data register and a status register with ready, overrun and framing-error flags.

Parameters:
- CLK_HZ, 576000, master clock frequency in Hz.
- BAUD, 115200, line bit rate.
- Derived: P = CLK_HZ/BAUD clocks per bit (5 at defaults). H = P/2, integer division, gives the half-bit delay (2 at defaults). Divider width = $clog2(P).

Ports:
- clk  input  1  master clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset. Low forces reset immediately; logic is released on the first clk edge after rst goes high.
- dbr  output 8  registered data bus read value.
- addr  input  1  register select: 0 = data, 1 = status.
- rd  input  1  read strobe, one cycle per CPU read.
- rx  input  1  asynchronous serial input, idle high.
- rx_irq  output 1  equals the ready flag (registered).

Behaviour:
- Reset values: dbr=0, rx_irq=0, ready=0, overrun=0, ferr=0, data=0, state=IDLE, divider=0, bit counter=0. Synchronizer flops reset to 1.
- Input sync: rx passes through 2 flops giving rxs. Everything below uses rxs only.
- Bus read, 1-cycle latency:
  - When rd=1, dbr is updated on the next edge.
  - addr=0: dbr = data. addr=1: dbr = {ready, overrun, ferr, 5'b0}.
  - When rd=0, dbr holds its value.
- Read side effects:
  - rd with addr=0 clears ready and overrun.
  - rd with addr=1 clears ferr.
  - Status reads never clear ready.
- State machine (divider counts clocks; a tick occurs when the divider reaches its terminal count, and the divider resets on every state change):
  - IDLE: on rxs=0, go to START and load the divider for H clocks.
  - START: at the H tick, sample rxs. If 0, go to DATA with bit count 0 and divider period P. If 1 (glitch), return to IDLE with no flag changes.
  - DATA: at each P tick, shift rxs into the shift register MSB side, so after 8 bits bit0 is the first received bit. Increment the bit count; after the 8th sample, go to STOP.
  - STOP: at the P tick, sample rxs.
    - If 1: data <= shift register; ready <= 1; overrun <= 1 if ready was already 1 (the new byte overwrites the old). Go to IDLE.
    - If 0: ferr <= 1, data and ready unchanged. Go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. This handles break without generating spurious frames.
- Timing: the sample point is H + k*P clocks after the first low rxs, for k = 0 (start), 1–8 (data), 9 (stop). Ready rises on the edge that samples the stop bit.
- Simultaneous events:
  - A data read in the same cycle as stop-bit completion: the new byte wins. Ready stays 1, overrun stays 0, and dbr returns the old data.
  - A status read in the same cycle as a framing error: ferr ends up 1.
- Reset mid-frame: immediate return to IDLE with all flags 0. A partially received byte is discarded. If rx is still low after reset release, it is treated as a new start edge.
- Divider and bit counter never wrap outside their defined ranges. The shift register is 8 bits.

Test Plan:
- Reset defaults: assert rst=0 with rx=1 → dbr=0 and rx_irq=0. Status read returns 0x00.
- Single byte: at defaults (P=5), send 0xA5 with a 5-clock bit time → rx_irq=1 within 2+47 clocks of the synced start edge. Status read gives 0x80; data read gives 0xA5; the following status read gives 0x00.
- Glitch rejection: drive rx low for 1 clock → no ready and no ferr. State returns to IDLE, shown by a following byte 0x3C received correctly.
- Overrun: send 0x11 then 0x22 with no read → status 0xC0, data read 0x22, then status 0x00.
- Framing error: send 0x7E with the stop bit held low for 20 clocks, then high → status 0x20, ready=0. A subsequent byte 0x81 gives data 0x81. Status read clears ferr.
- Reset mid-frame: assert rst during data bit 4 of 0xFF, release with rx=1 → no ready. The next byte 0x5A is received correctly. Also check a data read coinciding with stop completion: ready remains 1 and overrun remains 0.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling from a clock divider.
// CPU sees a data register (addr=0) and a status register (addr=1).
module uart_rx #(
  parameter int unsigned CLK_HZ = 576000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] dbr,
  input  logic       addr,
  input  logic       rd,
  input  logic       rx,
  output logic       rx_irq
);

  localparam int unsigned P     = CLK_HZ / BAUD;
  localparam int unsigned H     = P / 2;
  localparam int unsigned DIV_W = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned BIT_W = 3;

  localparam logic [DIV_W-1:0] FULL_TC = DIV_W'(P - 1);
  localparam logic [DIV_W-1:0] HALF_TC = DIV_W'((H > 0) ? (H - 1) : 0);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic [7:0]       shift;
  logic [7:0]       data;
  logic [1:0]       sync;
  logic             rxs;
  logic             ready, overrun, ferr;
  logic             shift_en, frame_ok, frame_err;
  logic             rd_data, rd_stat;

  assign rxs     = sync[1];
  assign rd_data = rd & ~addr;
  assign rd_stat = rd & addr;
  assign rx_irq  = ready;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], rx};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      div     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div     <= div_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  // Next state; divider is cleared on every state change
  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    bit_nxt   = bit_cnt;
    shift_en  = 1'b0;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    case (state)
      S_IDLE: begin
        div_nxt = '0;
        bit_nxt = '0;
        if (!rxs) state_nxt = S_START;
      end
      S_START: begin
        if (div == HALF_TC) begin
          div_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rxs ? S_IDLE : S_DATA;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (div == FULL_TC) begin
          div_nxt  = '0;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            bit_nxt   = '0;
            state_nxt = S_STOP;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (div == FULL_TC) begin
          div_nxt = '0;
          if (rxs) begin
            frame_ok  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = S_WAIT_HIGH;
          end
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        div_nxt = '0;
        bit_nxt = '0;
        if (rxs) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        div_nxt   = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // LSB arrives first, so shift in from the MSB side
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          shift <= '0;
    else if (shift_en) shift <= {rxs, shift[7:1]};
  end

  // Bus registers and flags; a completed frame beats a concurrent data read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbr     <= '0;
      data    <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (rd) dbr <= addr ? {ready, overrun, ferr, 5'b0} : data;

      if (frame_ok) begin
        data    <= shift;
        ready   <= 1'b1;
        overrun <= rd_data ? 1'b0 : (overrun | ready);
      end else if (rd_data) begin
        ready   <= 1'b0;
        overrun <= 1'b0;
      end

      if (frame_err)    ferr <= 1'b1;
      else if (rd_stat) ferr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, checked against
// a transaction-level model of the data/status registers.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 576000;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned P      = CLK_HZ / BAUD;
  localparam int unsigned H      = P / 2;
  // Negedges from driving the start bit low to the cycle whose edge samples the stop bit
  localparam int unsigned STOP_EDGE = 2 + 1 + H + 9 * P - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dbr;
  logic       addr;
  logic       rd;
  logic       rx;
  logic       rx_irq;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_data;
  logic       m_ready, m_ovr, m_ferr;
  logic [7:0] m_dbr;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk    (clk),
    .rst    (rst),
    .dbr    (dbr),
    .addr   (addr),
    .rd     (rd),
    .rx     (rx),
    .rx_irq (rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_dbr   = 8'h00;
  endtask

  task automatic model_frame(input logic [7:0] b);
    m_ovr   = m_ovr | m_ready;
    m_ready = 1'b1;
    m_data  = b;
  endtask

  task automatic drive_bit(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // stop_low == 0 gives a good stop bit, otherwise the line is held low that long
  task automatic send_frame(input logic [7:0] b, input int unsigned stop_low);
    @(negedge clk);
    drive_bit(1'b0, P);
    for (int i = 0; i < 8; i++) drive_bit(b[i], P);
    if (stop_low != 0) drive_bit(1'b0, stop_low);
    drive_bit(1'b1, P);
    drive_bit(1'b1, 8);
  endtask

  task automatic send_glitch();
    @(negedge clk);
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 10);
  endtask

  task automatic bus_read(input logic a, input string tag);
    logic [7:0] exp;
    exp = a ? {m_ready, m_ovr, m_ferr, 5'b0} : m_data;
    if (a) m_ferr = 1'b0;
    else begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
    rd   = 1'b1;
    addr = a;
    @(negedge clk);
    rd   = 1'b0;
    addr = 1'b0;
    check(tag, dbr, exp);
    m_dbr = exp;
  endtask

  task automatic check_irq(input string tag);
    check(tag, {7'b0, rx_irq}, {7'b0, m_ready});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp8;
    int unsigned lat;

    rst  = 1'b0;
    rx   = 1'b1;
    rd   = 1'b0;
    addr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_dbr", dbr, 8'h00);
    check_irq("rst_irq");
    rst = 1'b1;
    drive_bit(1'b1, 4);
    bus_read(1'b1, "rst_status");

    // Single byte with latency bound
    lat = 0;
    fork
      send_frame(8'hA5, 0);
      begin
        @(negedge clk);
        while (rx_irq !== 1'b1 && lat < 100) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    model_frame(8'hA5);
    check("a5_latency_ok", {7'b0, (lat >= 47 && lat <= 51)}, 8'h01);
    check_irq("a5_irq");
    bus_read(1'b1, "a5_status");
    bus_read(1'b0, "a5_data");
    bus_read(1'b1, "a5_status2");

    // Glitch rejection followed by a clean byte
    send_glitch();
    check_irq("glitch_irq");
    bus_read(1'b1, "glitch_status");
    send_frame(8'h3C, 0);
    model_frame(8'h3C);
    bus_read(1'b0, "3c_data");

    // Overrun
    send_frame(8'h11, 0);
    model_frame(8'h11);
    send_frame(8'h22, 0);
    model_frame(8'h22);
    bus_read(1'b1, "ovr_status");
    bus_read(1'b0, "ovr_data");
    bus_read(1'b1, "ovr_status2");

    // Framing error with long break, then recovery
    send_frame(8'h7E, 20);
    m_ferr = 1'b1;
    check_irq("ferr_irq");
    bus_read(1'b1, "ferr_status");
    send_frame(8'h81, 0);
    model_frame(8'h81);
    bus_read(1'b0, "81_data");
    bus_read(1'b1, "81_status");

    // Reset in the middle of data bit 4, with an unread byte pending
    send_frame(8'h33, 0);
    model_frame(8'h33);
    @(negedge clk);
    drive_bit(1'b0, P);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, P);
    drive_bit(1'b1, 2);
    rst = 1'b0;
    model_reset();
    drive_bit(1'b1, 3);
    check("midrst_dbr", dbr, 8'h00);
    check_irq("midrst_irq");
    rst = 1'b1;
    drive_bit(1'b1, 3 * P);
    check_irq("midrst_irq2");
    bus_read(1'b1, "midrst_status");
    send_frame(8'h5A, 0);
    model_frame(8'h5A);
    bus_read(1'b0, "5a_data");

    // Data read landing on the stop-bit sample edge
    send_frame(8'h44, 0);
    model_frame(8'h44);
    exp8    = m_data;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    fork
      send_frame(8'h99, 0);
      begin
        @(negedge clk);
        repeat (STOP_EDGE) @(negedge clk);
        rd   = 1'b1;
        addr = 1'b0;
        @(negedge clk);
        rd   = 1'b0;
        check("coinc_dbr", dbr, exp8);
      end
    join
    m_dbr = exp8;
    model_frame(8'h99);
    check_irq("coinc_irq");
    bus_read(1'b1, "coinc_status");
    bus_read(1'b0, "coinc_data");

    // Random mix of good frames, framing errors, glitches and reads
    for (int n = 0; n < 40; n++) begin
      int unsigned kind;
      logic [7:0]  b;
      kind = $urandom_range(0, 9);
      b    = 8'($urandom);
      if (kind == 0) send_glitch();
      else if (kind == 1) begin
        send_frame(b, $urandom_range(6, 25));
        m_ferr = 1'b1;
      end else begin
        send_frame(b, 0);
        model_frame(b);
      end
      drive_bit(1'b1, $urandom_range(0, 4));
      check_irq("rnd_irq");
      check("rnd_hold", dbr, m_dbr);
      if ($urandom_range(0, 1) == 1) bus_read(1'($urandom_range(0, 1)), "rnd_read");
    end
    bus_read(1'b1, "end_status");
    bus_read(1'b0, "end_data");
    bus_read(1'b1, "end_status2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
